eth_tx_pattern_gen: RTL and testbench
=====================================

# eth_tx_pattern_gen

Parametrised Ethernet TX test-pattern generator: on a synchronised rising edge of a start request it emits one or more frames of configurable length, pattern, inter-frame gap and repeat count on a valid/ready/last byte stream. It sits in `eth_proc` ahead of the TX framing path and supersedes the fixed 100-byte incrementing generator with a back-pressure-aware, multi-mode source.

## Interface
Parameters:
- DATA_W, 8: beat width in bits, 1..32.
- LEN_W, 11: width of frame-length field.
- CNT_W, 16: width of frame-count fields.

Ports:
- Clk  in  1  sole clock.
- Rst  in  1  synchronous reset, active-high.
- Tpg_Start  in  1  launch request, asynchronous to Clk; a rising edge launches a run; in continuous mode the level also keeps the run going.
- Tpg_Mode  in  2  pattern select: 0 INC, 1 CONST, 2 PRBS, 3 reserved (behaves as INC).
- Tpg_Seed  in  DATA_W  INC start value / CONST value / PRBS seed.
- Tpg_Len  in  LEN_W  beats per frame.
- Tpg_Gap  in  8  idle cycles between frames.
- Tpg_Frames  in  CNT_W  frames per run; 0 = continuous.
- Tpg_Ready  in  1  downstream accept.
- Tpg_Data  out  DATA_W  pattern beat.
- Tpg_Valid  out  1  beat valid.
- Tpg_Last  out  1  final beat of frame, qualified by Tpg_Valid.
- Tpg_Busy  out  1  run in progress.
- Tpg_Done  out  1  one-cycle pulse at run end.
- Tpg_Frame_Cnt  out  CNT_W  frames completed in current/last run.

## Operation
- Tpg_Start passes through a 2-flop synchroniser plus one delay flop; launch = synced & ~delayed, honoured only in IDLE. Edges while busy are ignored.
- On launch, Tpg_Mode/Seed/Len/Gap/Frames are latched; config inputs may change freely afterwards. Tpg_Frame_Cnt cleared.
- FSM: IDLE -> SEND (launch, Len≠0); IDLE -> IDLE with Done pulse (launch, Len==0). SEND -> GAP (last beat accepted, more frames, Gap≠0); SEND -> SEND (more frames, Gap==0; no Valid bubble); SEND -> IDLE (final frame done). GAP -> SEND after exactly Gap cycles with Tpg_Valid low.
- "More frames": Frames≠0 and Frame_Cnt+1 < Frames; or Frames==0 and synced Start still high. Continuous mode always finishes the current frame.
- Beat advances only on Tpg_Valid & Tpg_Ready; while Valid & ~Ready, Data/Last held stable. Valid never drops mid-frame.
- INC: first beat = Seed, +1 per accepted beat, wraps modulo 2^DATA_W; restarts at Seed every frame.
- CONST: every beat = Seed.
- PRBS: 32-bit Fibonacci LFSR, x^32+x^22+x^2+x+1, seeded with zero-extended Seed (0 replaced by all-ones); Data = low DATA_W bits; one step per accepted beat; not reseeded between frames.
- Tpg_Frame_Cnt increments on each accepted Last beat, saturating at all-ones.
- Reset values: Tpg_Data 0, Tpg_Valid 0, Tpg_Last 0, Tpg_Busy 0, Tpg_Done 0, Tpg_Frame_Cnt 0; FSM IDLE; synchroniser flops 0. Rst mid-frame aborts at the next edge with no Done pulse. A Start held high through reset launches once after reset releases.

## Timing
- Tpg_Start first sampled high at edge N -> Tpg_Valid, Tpg_Busy high after edge N+2 (3 edges latency); first beat present in that cycle.
- With Ready held high: one beat per cycle; frame of Len beats occupies exactly Len cycles.
- Tpg_Done and Busy falling: registered on the edge that accepts the final Last beat (Done high for the following cycle, Valid low the same cycle).
- Len==0: Done pulses after edge N+2, Busy stays low.
- All outputs registered; no combinational path from Tpg_Ready to any output.

## Configuration
- ETH_TPG_PRBS_EN defined: PRBS mode available, LFSR sub-module instantiated.
- Undefined: no LFSR logic; mode 2 behaves exactly as INC.

## Structure
- Shared package `eth_pkg`: mode typedef enum (TPG_INC, TPG_CONST, TPG_PRBS, TPG_RSVD), FSM state typedef, LFSR polynomial/all-ones seed constants.
- One sub-module: `eth_tpg_lfsr` (32-bit LFSR, load/step/seed inputs, 32-bit state out), instantiated only under ETH_TPG_PRBS_EN.

## Test plan
- INC, Seed=0xFE, Len=4, Frames=1, Gap=0, Ready=1 -> Data FE,FF,00,01; Last on 01; Done one cycle later; Frame_Cnt=1.
- CONST, Seed=0xA5, Len=3, Frames=3, Gap=2 -> three frames of A5×3, 2 idle cycles between, Frame_Cnt=3, single Done.
- Ready toggling 1,0,0,1,... during INC Len=8 -> Data/Last stable while stalled, exactly 8 accepted beats 0..7 (Seed=0).
- Frames=0 continuous, Len=5, Gap=0; drop Start mid-third frame -> third frame completes, no fourth, Frame_Cnt=3, Done.
- PRBS (macro defined), Seed=0 -> LFSR starts from all-ones, sequence matches model across frame boundary; macro undefined -> mode 2 output identical to INC.
- Rst asserted mid-frame, Start held high -> outputs 0 next edge, no Done; after release, new run launches, Valid 3 edges later.

Source files
------------

// File: rtl/eth_pkg.sv
// eth_pkg: shared types and constants for the Ethernet TX pattern generator
package eth_pkg;
  typedef enum logic [1:0] {TPG_INC, TPG_CONST, TPG_PRBS, TPG_RSVD} tpg_mode_e;
  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP} tpg_state_e;
  // x^32+x^22+x^2+x+1 feedback taps on state bits 31,21,1,0
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  localparam logic [31:0] LFSR_ONES = 32'hFFFF_FFFF;
endpackage

// File: rtl/eth_tpg_lfsr.sv
// eth_tpg_lfsr: 32-bit Fibonacci LFSR with load (zero seed maps to all-ones) and step
module eth_tpg_lfsr
  import eth_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_load,
  input  logic        i_step,
  input  logic [31:0] i_seed,
  output logic [31:0] o_state
);
  logic [31:0] r_state;
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= '0;
    else if (i_load) r_state <= (i_seed == '0) ? LFSR_ONES : i_seed;
    else if (i_step) r_state <= {r_state[30:0], ^(r_state & LFSR_TAPS)};
  end
  assign o_state = r_state;
endmodule

// File: rtl/eth_tx_pattern_gen.sv
// eth_tx_pattern_gen: multi-mode, back-pressure-aware TX test-pattern frame source.
// Define ETH_TPG_PRBS_EN to enable PRBS mode; otherwise mode 2 behaves as INC.
module eth_tx_pattern_gen
  import eth_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 11,
  parameter int CNT_W  = 16
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Tpg_Start,
  input  logic [1:0]        Tpg_Mode,
  input  logic [DATA_W-1:0] Tpg_Seed,
  input  logic [LEN_W-1:0]  Tpg_Len,
  input  logic [7:0]        Tpg_Gap,
  input  logic [CNT_W-1:0]  Tpg_Frames,
  input  logic              Tpg_Ready,
  output logic [DATA_W-1:0] Tpg_Data,
  output logic              Tpg_Valid,
  output logic              Tpg_Last,
  output logic              Tpg_Busy,
  output logic              Tpg_Done,
  output logic [CNT_W-1:0]  Tpg_Frame_Cnt
);
  tpg_state_e        r_state;
  tpg_mode_e         r_mode;
  logic              r_s1, r_s2, r_s3;
  logic [DATA_W-1:0] r_seed, r_data;
  logic [LEN_W-1:0]  r_len, r_rem;
  logic [7:0]        r_gap, r_gap_cnt;
  logic [CNT_W-1:0]  r_frames, r_frame_cnt;
  logic              r_valid, r_last, r_busy, r_done;
  logic              w_launch, w_acc, w_more;
  assign w_launch = r_s2 & ~r_s3 & (r_state == ST_IDLE);
  assign w_acc    = r_valid & Tpg_Ready;
  // continuous mode keeps going while the synchronised start level stays high
  assign w_more   = (r_frames != '0) ? (({1'b0, r_frame_cnt} + (CNT_W+1)'(1)) < {1'b0, r_frames}) : r_s2;
  always_ff @(posedge Clk) begin
    if (Rst) begin
      {r_s1, r_s2, r_s3} <= 3'b000;
      r_state     <= ST_IDLE;
      r_mode      <= TPG_INC;
      r_seed      <= '0;
      r_len       <= '0;
      r_gap       <= '0;
      r_frames    <= '0;
      r_rem       <= '0;
      r_gap_cnt   <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_last      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      {r_s3, r_s2, r_s1} <= {r_s2, r_s1, Tpg_Start};
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: if (w_launch) begin
          r_mode      <= tpg_mode_e'(Tpg_Mode);
          r_seed      <= Tpg_Seed;
          r_len       <= Tpg_Len;
          r_gap       <= Tpg_Gap;
          r_frames    <= Tpg_Frames;
          r_frame_cnt <= '0;
          if (Tpg_Len == '0) r_done <= 1'b1;
          else begin
            r_state <= ST_SEND;
            r_busy  <= 1'b1;
            r_valid <= 1'b1;
            r_data  <= Tpg_Seed;
            r_rem   <= Tpg_Len - LEN_W'(1);
            r_last  <= Tpg_Len == LEN_W'(1);
          end
        end
        ST_SEND: if (w_acc) begin
          if (!r_last) begin
            r_data <= (r_mode == TPG_CONST) ? r_seed : r_data + DATA_W'(1);
            r_rem  <= r_rem - LEN_W'(1);
            r_last <= r_rem == LEN_W'(1);
          end else begin
            r_frame_cnt <= &r_frame_cnt ? r_frame_cnt : r_frame_cnt + CNT_W'(1);
            if (!w_more) begin
              r_state <= ST_IDLE;
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else if (r_gap != '0) begin
              r_state   <= ST_GAP;
              r_valid   <= 1'b0;
              r_last    <= 1'b0;
              r_gap_cnt <= r_gap;
            end else begin
              r_data <= r_seed;
              r_rem  <= r_len - LEN_W'(1);
              r_last <= r_len == LEN_W'(1);
            end
          end
        end
        ST_GAP: if (r_gap_cnt == 8'd1) begin
          r_state <= ST_SEND;
          r_valid <= 1'b1;
          r_data  <= r_seed;
          r_rem   <= r_len - LEN_W'(1);
          r_last  <= r_len == LEN_W'(1);
        end else r_gap_cnt <= r_gap_cnt - 8'd1;
        default: r_state <= ST_IDLE;
      endcase
    end
  end
`ifdef ETH_TPG_PRBS_EN
  logic [31:0] w_lfsr;
  eth_tpg_lfsr u_lfsr (
    .i_clk  (Clk),
    .i_rst  (Rst),
    .i_load (w_launch),
    .i_step (w_acc && r_mode == TPG_PRBS),
    .i_seed (32'(Tpg_Seed)),
    .o_state(w_lfsr)
  );
  assign Tpg_Data = (r_mode == TPG_PRBS) ? w_lfsr[DATA_W-1:0] : r_data;
`else
  assign Tpg_Data = r_data;
`endif
  assign Tpg_Valid     = r_valid;
  assign Tpg_Last      = r_last;
  assign Tpg_Busy      = r_busy;
  assign Tpg_Done      = r_done;
  assign Tpg_Frame_Cnt = r_frame_cnt;
endmodule

// File: tb/tb_eth_tx_pattern_gen.sv
// tb_eth_tx_pattern_gen: directed self-checking bench for eth_tx_pattern_gen
module tb_eth_tx_pattern_gen;
  localparam int DW = 8, LW = 11, CW = 16;
  logic          Clk = 1'b0, Rst = 1'b1, Tpg_Start = 1'b0, Tpg_Ready = 1'b1;
  logic [1:0]    Tpg_Mode = '0;
  logic [DW-1:0] Tpg_Seed = '0;
  logic [LW-1:0] Tpg_Len = '0;
  logic [7:0]    Tpg_Gap = '0;
  logic [CW-1:0] Tpg_Frames = '0;
  logic [DW-1:0] Tpg_Data;
  logic          Tpg_Valid, Tpg_Last, Tpg_Busy, Tpg_Done;
  logic [CW-1:0] Tpg_Frame_Cnt;
  int n_chk = 0, n_fail = 0;

  eth_tx_pattern_gen #(.DATA_W(DW), .LEN_W(LW), .CNT_W(CW)) dut (
    .Clk(Clk), .Rst(Rst), .Tpg_Start(Tpg_Start), .Tpg_Mode(Tpg_Mode), .Tpg_Seed(Tpg_Seed),
    .Tpg_Len(Tpg_Len), .Tpg_Gap(Tpg_Gap), .Tpg_Frames(Tpg_Frames), .Tpg_Ready(Tpg_Ready),
    .Tpg_Data(Tpg_Data), .Tpg_Valid(Tpg_Valid), .Tpg_Last(Tpg_Last), .Tpg_Busy(Tpg_Busy),
    .Tpg_Done(Tpg_Done), .Tpg_Frame_Cnt(Tpg_Frame_Cnt)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic setup(input logic [1:0] m, input logic [7:0] s, input int l, input logic [7:0] g, input int f);
    Tpg_Mode = m; Tpg_Seed = s; Tpg_Len = LW'(l); Tpg_Gap = g; Tpg_Frames = CW'(f); Tpg_Start = 1'b1;
  endtask

  task automatic quiesce();
    Tpg_Start = 1'b0;
    Tpg_Ready = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    repeat (3) tick();
    n_chk++;
    if ({Tpg_Data, Tpg_Valid, Tpg_Last, Tpg_Busy, Tpg_Done, Tpg_Frame_Cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got data=%h v=%b l=%b b=%b d=%b cnt=%0d want all zero", Tpg_Data, Tpg_Valid, Tpg_Last, Tpg_Busy, Tpg_Done, Tpg_Frame_Cnt);
    end
    Rst = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_inc();
    logic [7:0] e;
    setup(2'd0, 8'hFE, 4, 8'd0, 1);
    tick(); tick();
    n_chk++;
    if (Tpg_Valid !== 1'b0) begin n_fail++; $display("FAIL inc_early_valid: got %b want 0", Tpg_Valid); end
    tick();
    Tpg_Start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      e = 8'hFE + 8'(k);
      n_chk++;
      if ({Tpg_Valid, Tpg_Busy, Tpg_Last, Tpg_Data} !== {1'b1, 1'b1, k == 3, e}) begin
        n_fail++;
        $display("FAIL inc_beat%0d: got v=%b b=%b l=%b d=%h want v=1 b=1 l=%b d=%h", k, Tpg_Valid, Tpg_Busy, Tpg_Last, Tpg_Data, k == 3, e);
      end
      tick();
    end
    n_chk++;
    if ({Tpg_Valid, Tpg_Busy, Tpg_Done, Tpg_Frame_Cnt} !== {3'b001, 16'd1}) begin
      n_fail++;
      $display("FAIL inc_done: got v=%b b=%b d=%b cnt=%0d want v=0 b=0 d=1 cnt=1", Tpg_Valid, Tpg_Busy, Tpg_Done, Tpg_Frame_Cnt);
    end
    tick();
    n_chk++;
    if (Tpg_Done !== 1'b0) begin n_fail++; $display("FAIL inc_done_width: got %b want 0", Tpg_Done); end
    quiesce();
  endtask

  task automatic test_const_gap();
    logic v;
    setup(2'd1, 8'hA5, 3, 8'd2, 3);
    repeat (3) tick();
    Tpg_Start = 1'b0;
    for (int c = 0; c < 13; c++) begin
      v = (c % 5) < 3;
      n_chk++;
      if (Tpg_Valid !== v || (v && {Tpg_Data, Tpg_Last} !== {8'hA5, c % 5 == 2}) || Tpg_Done !== 1'b0) begin
        n_fail++;
        $display("FAIL const_cycle%0d: got v=%b d=%h l=%b done=%b want v=%b d=a5 l=%b done=0", c, Tpg_Valid, Tpg_Data, Tpg_Last, Tpg_Done, v, c % 5 == 2);
      end
      tick();
    end
    n_chk++;
    if ({Tpg_Done, Tpg_Busy, Tpg_Frame_Cnt} !== {2'b10, 16'd3}) begin
      n_fail++;
      $display("FAIL const_done: got d=%b b=%b cnt=%0d want d=1 b=0 cnt=3", Tpg_Done, Tpg_Busy, Tpg_Frame_Cnt);
    end
    tick();
    n_chk++;
    if (Tpg_Done !== 1'b0) begin n_fail++; $display("FAIL const_single_done: got %b want 0", Tpg_Done); end
    quiesce();
  endtask

  task automatic test_backpressure();
    int idx = 0;
    logic [7:0] pd = '0;
    logic pl = 1'b0, stalled = 1'b0;
    setup(2'd0, 8'h00, 8, 8'd0, 1);
    repeat (3) tick();
    Tpg_Start = 1'b0;
    for (int c = 0; c < 40 && idx < 8; c++) begin
      Tpg_Ready = (c % 4 == 0) || (c % 4 == 3);
      n_chk++;
      if (Tpg_Valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_c%0d: got %b want 1", c, Tpg_Valid); end
      if (stalled) begin
        n_chk++;
        if ({Tpg_Last, Tpg_Data} !== {pl, pd}) begin
          n_fail++;
          $display("FAIL bp_hold_c%0d: got l=%b d=%h want l=%b d=%h", c, Tpg_Last, Tpg_Data, pl, pd);
        end
      end
      if (Tpg_Ready) begin
        n_chk++;
        if ({Tpg_Last, Tpg_Data} !== {idx == 7, 8'(idx)}) begin
          n_fail++;
          $display("FAIL bp_beat%0d: got l=%b d=%h want l=%b d=%h", idx, Tpg_Last, Tpg_Data, idx == 7, 8'(idx));
        end
        idx++;
      end
      stalled = !Tpg_Ready;
      pd = Tpg_Data;
      pl = Tpg_Last;
      tick();
    end
    Tpg_Ready = 1'b1;
    n_chk++;
    if (idx != 8 || {Tpg_Valid, Tpg_Done} !== 2'b01) begin
      n_fail++;
      $display("FAIL bp_end: got beats=%0d v=%b d=%b want beats=8 v=0 d=1", idx, Tpg_Valid, Tpg_Done);
    end
    quiesce();
  endtask

  task automatic test_continuous();
    int idx = 0;
    setup(2'd0, 8'h10, 5, 8'd0, 0);
    repeat (3) tick();
    for (int c = 0; c < 30 && idx < 15; c++) begin
      n_chk++;
      if ({Tpg_Valid, Tpg_Last, Tpg_Data} !== {1'b1, idx % 5 == 4, 8'h10 + 8'(idx % 5)}) begin
        n_fail++;
        $display("FAIL cont_beat%0d: got v=%b l=%b d=%h want v=1 l=%b d=%h", idx, Tpg_Valid, Tpg_Last, Tpg_Data, idx % 5 == 4, 8'h10 + 8'(idx % 5));
      end
      if (idx == 12) Tpg_Start = 1'b0;
      idx++;
      tick();
    end
    n_chk++;
    if ({Tpg_Valid, Tpg_Done, Tpg_Frame_Cnt} !== {2'b01, 16'd3}) begin
      n_fail++;
      $display("FAIL cont_done: got v=%b d=%b cnt=%0d want v=0 d=1 cnt=3", Tpg_Valid, Tpg_Done, Tpg_Frame_Cnt);
    end
    repeat (3) tick();
    n_chk++;
    if ({Tpg_Valid, Tpg_Busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL cont_no_fourth: got v=%b b=%b want 0 0", Tpg_Valid, Tpg_Busy);
    end
    quiesce();
  endtask

  task automatic test_prbs();
    logic [31:0] m = 32'hFFFF_FFFF;
    logic [7:0] e;
    logic v;
    setup(2'd2, 8'h00, 3, 8'd1, 2);
    repeat (3) tick();
    Tpg_Start = 1'b0;
    for (int c = 0; c < 7; c++) begin
      v = c != 3;
`ifdef ETH_TPG_PRBS_EN
      e = m[7:0];
`else
      e = 8'((c < 3) ? c : c - 4);
`endif
      n_chk++;
      if (Tpg_Valid !== v || (v && Tpg_Data !== e)) begin
        n_fail++;
        $display("FAIL prbs_cycle%0d: got v=%b d=%h want v=%b d=%h", c, Tpg_Valid, Tpg_Data, v, e);
      end
      if (v) m = {m[30:0], m[31] ^ m[21] ^ m[1] ^ m[0]};
      tick();
    end
    n_chk++;
    if ({Tpg_Done, Tpg_Frame_Cnt} !== {1'b1, 16'd2}) begin
      n_fail++;
      $display("FAIL prbs_done: got d=%b cnt=%0d want d=1 cnt=2", Tpg_Done, Tpg_Frame_Cnt);
    end
    quiesce();
  endtask

  task automatic test_len_zero();
    setup(2'd0, 8'h00, 0, 8'd0, 1);
    tick(); tick();
    n_chk++;
    if (Tpg_Done !== 1'b0) begin n_fail++; $display("FAIL len0_early: got done=%b want 0", Tpg_Done); end
    tick();
    n_chk++;
    if ({Tpg_Done, Tpg_Busy, Tpg_Valid} !== 3'b100) begin
      n_fail++;
      $display("FAIL len0_done: got d=%b b=%b v=%b want d=1 b=0 v=0", Tpg_Done, Tpg_Busy, Tpg_Valid);
    end
    tick();
    n_chk++;
    if (Tpg_Done !== 1'b0) begin n_fail++; $display("FAIL len0_pulse: got done=%b want 0", Tpg_Done); end
    quiesce();
  endtask

  task automatic test_reset_midframe();
    setup(2'd0, 8'h20, 10, 8'd0, 1);
    repeat (5) tick();
    Rst = 1'b1;
    tick();
    n_chk++;
    if ({Tpg_Data, Tpg_Valid, Tpg_Last, Tpg_Busy, Tpg_Done, Tpg_Frame_Cnt} !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: got d=%h v=%b l=%b b=%b done=%b cnt=%0d want all zero", Tpg_Data, Tpg_Valid, Tpg_Last, Tpg_Busy, Tpg_Done, Tpg_Frame_Cnt);
    end
    tick();
    Rst = 1'b0;
    tick(); tick();
    n_chk++;
    if ({Tpg_Valid, Tpg_Done} !== 2'b00) begin
      n_fail++;
      $display("FAIL rst_relaunch_early: got v=%b d=%b want 0 0", Tpg_Valid, Tpg_Done);
    end
    tick();
    n_chk++;
    if ({Tpg_Valid, Tpg_Data} !== {1'b1, 8'h20}) begin
      n_fail++;
      $display("FAIL rst_relaunch: got v=%b d=%h want v=1 d=20", Tpg_Valid, Tpg_Data);
    end
    Tpg_Start = 1'b0;
    for (int c = 0; c < 15 && !Tpg_Done; c++) tick();
    n_chk++;
    if ({Tpg_Done, Tpg_Frame_Cnt} !== {1'b1, 16'd1}) begin
      n_fail++;
      $display("FAIL rst_relaunch_done: got d=%b cnt=%0d want d=1 cnt=1", Tpg_Done, Tpg_Frame_Cnt);
    end
    quiesce();
  endtask

  initial begin
    test_reset();
    test_inc();
    test_const_gap();
    test_backpressure();
    test_continuous();
    test_prbs();
    test_len_zero();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
